updown_count_sched: RTL
=======================

UPDOWN_COUNT_SCHED -- requirements
Module: updown_count_sched

Interface
REQ-001 clk  input  1  rising-edge clock; all state changes occur on this edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req  input  2  per-requester request, bit i = requester i.
REQ-004 dir0  input  1  requester 0 direction: 1 = up, 0 = down.
REQ-005 dir1  input  1  requester 1 direction: 1 = up, 0 = down.
REQ-006 steps0  input  3  requester 0 step count, 0..7.
REQ-007 steps1  input  3  requester 1 step count, 0..7.
REQ-008 abort  input  1  terminates the active run early.
REQ-009 gnt  output  2  one-hot grant, or 00 when no requester is granted.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 count  output  3  value of the shared 3-bit up/down counter.

Function
REQ-013 The block SHALL implement FSM states IDLE, GRANT, RUN and DONE.
REQ-014 IDLE with req != 00 SHALL go to GRANT on the next edge, selecting the winner by round-robin.
REQ-015 Round-robin: with one request pending, grant it; with req = 11, grant the requester not granted last.
REQ-016 On entry to GRANT, the block SHALL latch the winner's dir and steps into internal registers dir_q and rem.
REQ-017 GRANT SHALL last one cycle: go to RUN if rem != 0, else to DONE.
REQ-018 In RUN, each edge SHALL step count by +1 (dir_q = 1) or -1 (dir_q = 0), modulo 8, and decrement rem.
REQ-019 RUN SHALL go to DONE on the edge where rem decrements to 0, so count changes exactly steps times.
REQ-020 Wrap-around: up from 7 SHALL give 0; down from 0 SHALL give 7.
REQ-021 abort sampled high in RUN SHALL go to DONE on that edge with no count step on that edge.
REQ-022 abort SHALL be ignored in IDLE, GRANT and DONE.
REQ-023 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-024 gnt SHALL be one-hot from GRANT through DONE inclusive and 00 in IDLE.
REQ-025 A request dropped mid-run SHALL NOT cancel the run.
REQ-026 A request held through DONE SHALL be re-arbitrated from IDLE: at least one idle cycle between grants.
REQ-027 Changes to dir/steps inputs after GRANT SHALL NOT affect the active run.
REQ-028 count SHALL hold its value outside RUN and SHALL persist across grants; grant does not clear it.

Reset
REQ-029 rst SHALL force state = IDLE, count = 0, gnt = 00, busy = 0, done = 0, rem = 0, and last-granted pointer = 1 (requester 0 wins the first tie).
REQ-030 rst SHALL override all other inputs, including mid-RUN, with no done pulse.

Structure
REQ-031 The shared package SHALL hold the state encoding (IDLE = 2'd0, GRANT = 1, RUN = 2, DONE = 3), the count width (3) and the requester count (2).
REQ-032 The counter datapath SHALL be a sub-module updown_counter3 (ports clk, rst, en, up, count) driven by the FSM.

Verification
REQ-033 Bench: rst for 2 cycles -> count = 0, gnt = 00, busy = 0, done = 0.
REQ-034 Bench: from count = 0, req = 01, dir0 = 1, steps0 = 3 -> GRANT, then count 1, 2, 3, then done pulse once; busy high for 5 cycles; gnt = 01 throughout.
REQ-035 Bench: after reset, req = 11 held -> grant 01 run completes, one IDLE cycle, then grant 10.
REQ-036 Bench: count = 6, up with steps 3 -> count 7, 0, 1; then down from 0 with steps 2 -> 7, 6.
REQ-037 Bench: steps0 = 0 -> GRANT then DONE, with count unchanged.
REQ-038 Bench: abort during RUN of steps 7 after 2 steps -> DONE with count = start ± 2.
REQ-039 Bench: rst mid-RUN -> IDLE, count = 0, no done pulse.

Source files
------------

// File: rtl/updown_count_sched_pkg.sv
// Shared types and sizing for the up/down count scheduler.
// Imported by the interface, counter and top.
package updown_count_sched_pkg;

  localparam int CNT_W = 3;
  localparam int NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/updown_count_sched_if.sv
// Request/grant bundle between requesters and the scheduler.
// The master side drives requests; the slave side is the scheduler.
interface updown_count_sched_if;
  import updown_count_sched_pkg::*;

  logic [NREQ-1:0]  req;
  logic             dir0;
  logic             dir1;
  logic [CNT_W-1:0] steps0;
  logic [CNT_W-1:0] steps1;
  logic             abort;
  logic [NREQ-1:0]  gnt;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output req, dir0, dir1, steps0, steps1, abort,
    input  gnt, busy, done, count
  );

  modport slave (
    input  req, dir0, dir1, steps0, steps1, abort,
    output gnt, busy, done, count
  );

endinterface

// File: rtl/updown_count_sched_counter3.sv
// Shared 3-bit wrapping up/down counter.
// Steps only when enabled; holds otherwise.
module updown_counter3
  import updown_count_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en)
      count <= up ? count + 1'b1 : count - 1'b1;
  end

endmodule

// File: rtl/updown_count_sched.sv
// Two-requester round-robin scheduler driving a shared
// up/down counter for a latched number of steps.
module updown_count_sched
  import updown_count_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  updown_count_sched_if.slave bus
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] rem;
  logic             dir_q;
  logic             last;
  logic             win;
  logic             step;
  logic             arb;

  // last = 1 means requester 1 holds the pointer, so 0 wins a tie
  always_comb begin
    win = ~last;
    if (bus.req == 2'b01)
      win = 1'b0;
    else if (bus.req == 2'b10)
      win = 1'b1;
  end

  assign arb  = (state == IDLE) && (|bus.req);
  assign step = (state == RUN) && !bus.abort;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (|bus.req) state_n = GRANT;
      GRANT: state_n = (rem != '0) ? RUN : DONE;
      RUN:   if (bus.abort || rem == 3'd1) state_n = DONE;
      DONE:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      dir_q <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      if (arb) begin
        last  <= win;
        dir_q <= win ? bus.dir1 : bus.dir0;
        rem   <= win ? bus.steps1 : bus.steps0;
      end else if (step) begin
        rem <= rem - 1'b1;
      end
    end
  end

  // The pointer is updated on grant, so it names the current owner
  assign bus.gnt  = (state == IDLE) ? 2'b00
                  : (last ? 2'b10 : 2'b01);
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  updown_counter3 u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (step),
    .up    (dir_q),
    .count (bus.count)
  );

endmodule
